// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one word read at a time to instruction
// memory, holds the returned word for the core and moves pc to the
// core-supplied successor when the core takes the instruction.
module ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic              resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] next_pc,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] instr_reg, instr_next;
    logic              err_reg, err_next;
    logic [ADDR_W-1:0] err_addr_reg, err_addr_next;
    logic [31:0]       cnt_reg, cnt_next;

    // State and datapath registers; reset wins over everything, which also
    // drops any response still in flight from before the reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            err_reg      <= err_next;
            err_addr_reg <= err_addr_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Next-state and datapath update; only one request is ever outstanding
    // because a new request is issued only after the previous instruction
    // has been handed over.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        err_next      = err_reg;
        err_addr_next = err_addr_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                // responses here cannot belong to a live request
                if (req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    if (resp_err) begin
                        err_next      = 1'b1;
                        err_addr_next = pc_reg;
                        state_next    = S_ERR;
                    end else begin
                        instr_next = resp_data;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    cnt_next = cnt_reg + 32'd1;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_next    = next_pc;
                        state_next = S_REQ;
                    end else begin
                        // misaligned target: keep pc of the last good fetch
                        err_next      = 1'b1;
                        err_addr_next = next_pc;
                        state_next    = S_ERR;
                    end
                end
            end
            S_ERR: begin
                // terminal until reset
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers or the state decode.
    assign req_valid   = (state_reg == S_REQ);
    assign inst_valid  = (state_reg == S_HOLD);
    assign req_addr    = pc_reg;
    assign pc          = pc_reg;
    assign instruction = instr_reg;
    assign fetch_err   = err_reg;
    assign err_addr    = err_addr_reg;
    assign fetch_cnt   = cnt_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: the bench plays both instruction memory and
// core, drives inputs on the falling edge and samples outputs there too.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        fetch_err;
    logic [31:0] err_addr;
    logic [31:0] fetch_cnt;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] exp_cnt;
    int          t_first;
    int          t_second;

    ifu_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .instruction(instruction),
        .pc         (pc),
        .next_pc    (next_pc),
        .fetch_err  (fetch_err),
        .err_addr   (err_addr),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // one full clock, ending on the falling edge where checks happen
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_cnt = 32'd0;
    endtask

    // Expects S_REQ at entry; optionally stalls the request (with one
    // spurious response pulse inside the stall), then answers after delay.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input logic err, input int req_stall, input int resp_delay);
        for (int i = 0; i < req_stall; i++) begin
            chk("req_valid_stall", req_valid, 1'b1);
            chk("req_addr_stall", req_addr, addr);
            if (i == 1) begin
                resp_valid = 1'b1;
                resp_data  = 32'hBAD0_BAD0;
                resp_err   = 1'b0;
            end
            tick();
            resp_valid = 1'b0;
        end
        chk("req_valid", req_valid, 1'b1);
        chk("req_addr", req_addr, addr);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < resp_delay; i++) begin
            chk("wait_no_valid", {req_valid, inst_valid}, 2'b00);
            tick();
        end
        resp_valid = 1'b1;
        resp_data  = data;
        resp_err   = err;
        tick();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
    endtask

    // Expects S_HOLD at entry; stalls the core, then accepts with npc.
    task automatic do_accept(input logic [31:0] inst, input logic [31:0] addr,
                             input logic [31:0] npc, input int hold_stall);
        for (int i = 0; i < hold_stall; i++) begin
            chk("inst_stall", instruction, inst);
            chk("pc_stall", pc, addr);
            chk("cnt_stall", fetch_cnt, exp_cnt);
            tick();
        end
        chk("inst_valid", inst_valid, 1'b1);
        chk("instruction", instruction, inst);
        chk("pc", pc, addr);
        inst_ready = 1'b1;
        next_pc    = npc;
        tick();
        inst_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        chk("fetch_cnt", fetch_cnt, exp_cnt);
    endtask

    initial begin
        rst = 1'b1;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        resp_data = 32'd0;
        resp_err = 1'b0;
        inst_ready = 1'b0;
        next_pc = 32'd0;
        exp_cnt = 32'd0;
        t_first = 0;
        t_second = 0;

        // reset state and first request
        tick();
        tick();
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_err", {fetch_err, err_addr}, 33'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        rst = 1'b0;
        chk("idle_req_valid", req_valid, 1'b0);
        tick();
        chk("first_req_valid", req_valid, 1'b1);
        chk("first_req_addr", req_addr, 32'h8000_0000);

        // back-to-back fetch, 3 cycles per instruction
        do_fetch(32'h8000_0000, 32'h0050_0093, 1'b0, 0, 0);
        t_first = cyc;
        do_accept(32'h0050_0093, 32'h8000_0000, 32'h8000_0004, 0);
        do_fetch(32'h8000_0004, 32'h0010_0113, 1'b0, 0, 0);
        t_second = cyc;
        do_accept(32'h0010_0113, 32'h8000_0004, 32'h8000_0008, 0);
        chk("throughput", t_second - t_first, 3);
        chk("cnt_two", fetch_cnt, 32'd2);

        // stalls on both sides, then a jump
        do_fetch(32'h8000_0008, 32'h0020_8193, 1'b0, 4, 2);
        do_accept(32'h0020_8193, 32'h8000_0008, 32'h8000_0100, 5);
        do_fetch(32'h8000_0100, 32'h0000_0013, 1'b0, 0, 1);
        do_accept(32'h0000_0013, 32'h8000_0100, 32'h8000_0104, 0);

        // access fault at 0x8000_0008
        do_reset();
        do_fetch(32'h8000_0000, 32'h1111_1111, 1'b0, 0, 0);
        do_accept(32'h1111_1111, 32'h8000_0000, 32'h8000_0004, 0);
        do_fetch(32'h8000_0004, 32'h2222_2222, 1'b0, 0, 0);
        do_accept(32'h2222_2222, 32'h8000_0004, 32'h8000_0008, 0);
        do_fetch(32'h8000_0008, 32'h3333_3333, 1'b1, 0, 0);
        chk("resp_err_flag", fetch_err, 1'b1);
        chk("resp_err_addr", err_addr, 32'h8000_0008);
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp_data  = 32'h4444_4444;
            tick();
            resp_valid = 1'b0;
            chk("err_quiet", {req_valid, inst_valid}, 2'b00);
        end
        chk("err_instruction", instruction, 32'h2222_2222);
        chk("err_cnt", fetch_cnt, 32'd2);
        req_ready  = 1'b0;
        inst_ready = 1'b0;

        // misaligned next_pc
        do_reset();
        do_fetch(32'h8000_0000, 32'h5555_5555, 1'b0, 0, 0);
        do_accept(32'h5555_5555, 32'h8000_0000, 32'h8000_0002, 0);
        chk("misalign_flag", fetch_err, 1'b1);
        chk("misalign_addr", err_addr, 32'h8000_0002);
        chk("misalign_pc", pc, 32'h8000_0000);
        chk("misalign_quiet", {req_valid, inst_valid}, 2'b00);

        // reset while waiting, stale response afterwards
        do_reset();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("wait_state", {req_valid, inst_valid}, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        tick();
        chk("stale_req_valid", req_valid, 1'b1);
        chk("stale_req_addr", req_addr, 32'h8000_0000);
        tick();
        resp_valid = 1'b0;
        chk("stale_in_req", {req_valid, inst_valid}, 2'b10);
        chk("stale_instruction", instruction, 32'd0);
        exp_cnt = 32'd0;

        // counter wrap: preload the count register while holding
        do_fetch(32'h8000_0000, 32'h6666_6666, 1'b0, 0, 0);
        force dut.cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_reg;
        chk("preload_cnt", fetch_cnt, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        do_accept(32'h6666_6666, 32'h8000_0000, 32'h8000_0004, 0);
        chk("wrap_cnt", fetch_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit that drives the core's `instruction` and `pc` inputs and consumes its `next_pc` output.
- Issues word reads to instruction memory over a valid/ready request channel and accepts data on a valid response channel.
- Presents one instruction at a time to the core with a valid/ready handshake.
- Advances `pc` to the core-supplied `next_pc` when the core accepts an instruction.

Parameters:
- ADDR_W, 32, width of `pc`, `req_addr`, `next_pc` and `err_addr`.
- DATA_W, 32, instruction/response data width.
- RESET_PC, 32'h8000_0000, fetch address after reset; must be 4-byte aligned.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  output  1  memory read request valid
- req_ready  input  1  memory accepts request
- req_addr  output  ADDR_W  read address; always equals `pc`
- resp_valid  input  1  memory response valid, one-cycle pulse
- resp_data  input  DATA_W  fetched instruction word
- resp_err  input  1  access fault; qualified by `resp_valid`
- inst_valid  output  1  instruction/pc pair is valid for the core
- inst_ready  input  1  core consumes the instruction this cycle
- instruction  output  DATA_W  held instruction word
- pc  output  ADDR_W  address of `instruction`
- next_pc  input  ADDR_W  core-computed successor pc; sampled on inst handshake
- fetch_err  output  1  sticky fault flag
- err_addr  output  ADDR_W  faulting address
- fetch_cnt  output  32  count of instructions handed to the core

Behaviour:
- **Clock/reset:** all state on rising `clk`; `rst` synchronous, active-high, takes priority over every other input, including mid-transaction.
- **Reset values:**
  - state=S_IDLE
  - pc=RESET_PC
  - instruction=0
  - fetch_err=0
  - err_addr=0
  - fetch_cnt=0
  - req_valid=0
  - inst_valid=0
- **Output decoding:** all outputs are registers or decoded from state only; no input-to-output combinational path.
  - req_valid = (state==S_REQ)
  - inst_valid = (state==S_HOLD)
  - req_addr = pc
- **State transitions:**
  - S_IDLE: unconditionally -> S_REQ next cycle. First req_valid is asserted one cycle after rst deasserts.
  - S_REQ: `req_valid` held high and `req_addr` stable until `req_ready`. On req_valid&req_ready -> S_WAIT. `resp_valid` in S_REQ is ignored.
  - S_WAIT: waits any number of cycles. On `resp_valid`:
    - if `resp_err`=0: instruction<=resp_data, -> S_HOLD.
    - if `resp_err`=1: fetch_err<=1, err_addr<=pc, -> S_ERR.
  - S_HOLD: `instruction` and `pc` stable while inst_valid=1 and inst_ready=0. On inst_valid&inst_ready:
    - fetch_cnt<=fetch_cnt+1 (wraps 2^32-1 -> 0).
    - if next_pc[1:0]==0: pc<=next_pc, -> S_REQ.
    - otherwise: fetch_err<=1, err_addr<=next_pc, pc unchanged, -> S_ERR.
  - S_ERR: terminal. All handshake outputs are 0 and `resp_valid` is ignored. Left only by `rst`.
- **Throughput:** minimum 3 cycles per instruction, with req_ready=1, a response the cycle after the request handshake, and inst_ready=1.
- **Outstanding requests:** at most one at any time.
- **Address arithmetic:** `next_pc` is taken verbatim (no +4 inside this block); `pc` wraps naturally at ADDR_W.
- **Reset mid-transaction:** a `resp_valid` arriving after `rst` for a request issued before `rst` is dropped, because the state is S_IDLE or S_REQ at that point.

Test Plan:
- **Reset and first request:** rst high for 2 cycles, then low -> req_valid=0 during reset; req_valid=1 with req_addr=32'h8000_0000 on the first cycle after rst low; fetch_cnt=0.
- **Back-to-back fetch:** req_ready=1; mem answers 0x00500093 @0x8000_0000 and 0x00100113 @0x8000_0004; inst_ready=1; next_pc=pc+4 -> each instruction appears with the matching pc on inst_valid; 3 cycles/instr; fetch_cnt=2.
- **Stalls on both sides:**
  - req_ready low 4 cycles -> req_valid and req_addr stable throughout.
  - inst_ready low 5 cycles -> instruction and pc unchanged, fetch_cnt unchanged.
  - Jump next_pc=0x8000_0100 -> next req_addr=0x8000_0100.
- **Fault paths:**
  - resp_err=1 at 0x8000_0008 -> fetch_err=1, err_addr=0x8000_0008, no further req_valid/inst_valid.
  - Separately, next_pc=0x8000_0002 -> fetch_err=1, err_addr=0x8000_0002.
- **Reset mid-transaction and spurious response:**
  - rst asserted in S_WAIT, then a stale resp_valid arrives -> it is ignored; fresh request to 0x8000_0000.
  - resp_valid during S_REQ -> ignored.
- **Counter wrap:** preload via 2^32-1 handshakes in a forced state, or accelerated check -> fetch_cnt rolls to 0 on the next accepted instruction.
